// File: rtl/mem_arbiter.sv
// Round-robin byte-serial memory controller.
// Serialises 1/2/4-byte accesses from several ports onto one byte-wide RAM.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_PORTS  = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_in,
    input  logic [NUM_PORTS-1:0]            req_in,
    input  logic [NUM_PORTS-1:0]            we_in,
    input  logic [2*NUM_PORTS-1:0]          size_in,
    input  logic [ADDR_WIDTH*NUM_PORTS-1:0] addr_in,
    input  logic [32*NUM_PORTS-1:0]         wdata_in,
    output logic [NUM_PORTS-1:0]            done_out,
    output logic [31:0]                     rdata_out,
    input  logic [7:0]                      ram_data_in,
    output logic [7:0]                      ram_data_out,
    output logic [ADDR_WIDTH-1:0]           ram_address_out,
    output logic                            ram_rw_signal_out
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e                 state_q;
    logic [PW-1:0]          rr_q;
    logic [PW-1:0]          gnt_q;
    logic                   we_q;
    logic [2:0]             n_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [31:0]            wdata_q;
    logic [31:0]            res_q;
    logic [2:0]             ic_q;
    logic [2:0]             rc_q;
    logic [NUM_PORTS-1:0]   done_q;
    logic [31:0]            rdata_q;

    logic                   pick_vld_d;
    logic [PW-1:0]          pick_d;
    logic [PW-1:0]          rr_d;
    logic [PW:0]            idx_sum;
    logic [2:0]             n_d;
    logic [31:0]            res_d;
    logic [2:0]             off;

    logic [ADDR_WIDTH-1:0]  addr_a  [NUM_PORTS];
    logic [31:0]            wdata_a [NUM_PORTS];
    logic [1:0]             size_a  [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign addr_a[p]  = addr_in[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[p] = wdata_in[p*32 +: 32];
        assign size_a[p]  = size_in[p*2 +: 2];
    end

    // Pick the first requester at or after rr, wrapping around.
    always_comb begin
        pick_vld_d = 1'b0;
        pick_d     = '0;
        idx_sum    = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx_sum = {1'b0, rr_q} + (PW+1)'(i);
            if (idx_sum >= (PW+1)'(NUM_PORTS)) begin
                idx_sum = idx_sum - (PW+1)'(NUM_PORTS);
            end
            if (req_in[idx_sum[PW-1:0]]) begin
                pick_vld_d = 1'b1;
                pick_d     = idx_sum[PW-1:0];
            end
        end
        rr_d = (pick_d == PW'(NUM_PORTS - 1)) ? '0 : pick_d + PW'(1);
        unique case (size_a[pick_d])
            2'd0:    n_d = 3'd1;
            2'd1:    n_d = 3'd2;
            default: n_d = 3'd4;
        endcase
    end

    // Merge the incoming RAM byte into the partial read result.
    always_comb begin
        res_d = res_q;
        res_d[{rc_q[1:0], 3'b000} +: 8] = ram_data_in;
    end

    // RAM bus is driven only while busy; reads park on the last byte.
    always_comb begin
        off               = (ic_q < n_q) ? ic_q : n_q - 3'd1;
        ram_address_out   = '0;
        ram_data_out      = '0;
        ram_rw_signal_out = 1'b0;
        if (state_q == S_BUSY) begin
            ram_address_out = addr_q + ADDR_WIDTH'(off);
            if (we_q) begin
                ram_rw_signal_out = 1'b1;
                ram_data_out      = wdata_q[{off[1:0], 3'b000} +: 8];
            end
        end
    end

    // Access sequencer: grant, issue/capture bytes, signal completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            n_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            res_q   <= '0;
            ic_q    <= '0;
            rc_q    <= '0;
            done_q  <= '0;
            rdata_q <= '0;
        end else begin
            done_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (pick_vld_d) begin
                        state_q <= S_BUSY;
                        gnt_q   <= pick_d;
                        rr_q    <= rr_d;
                        we_q    <= we_in[pick_d];
                        n_q     <= n_d;
                        addr_q  <= addr_a[pick_d];
                        wdata_q <= wdata_a[pick_d];
                        ic_q    <= '0;
                        rc_q    <= '0;
                        res_q   <= '0;
                    end
                end
                S_BUSY: begin
                    if (we_q) begin
                        ic_q <= ic_q + 3'd1;
                        if (ic_q == n_q - 3'd1) begin
                            state_q       <= S_DONE;
                            done_q[gnt_q] <= 1'b1;
                            rdata_q       <= '0;
                        end
                    end else if (flush_in) begin
                        state_q <= S_IDLE;
                    end else begin
                        if (ic_q < n_q) begin
                            ic_q <= ic_q + 3'd1;
                        end
                        if (ic_q != 3'd0) begin
                            res_q <= res_d;
                            rc_q  <= rc_q + 3'd1;
                            if (rc_q == n_q - 3'd1) begin
                                state_q       <= S_DONE;
                                done_q[gnt_q] <= 1'b1;
                                rdata_q       <= res_d;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    rdata_q <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done_out  = done_q;
    assign rdata_out = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, cycle-trace reference model,
// per-cycle comparison and directed scenarios.
module tb_mem_arbiter;

    localparam int NP     = 2;
    localparam int K_IDLE = 0;
    localparam int K_BW   = 1;
    localparam int K_BR   = 2;
    localparam int K_DN   = 3;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              flush_in = 1'b0;
    logic [NP-1:0]     req_in   = '0;
    logic [NP-1:0]     we_in    = '0;
    logic [2*NP-1:0]   size_in  = '0;
    logic [32*NP-1:0]  addr_in  = '0;
    logic [32*NP-1:0]  wdata_in = '0;
    logic [NP-1:0]     done_out;
    logic [31:0]       rdata_out;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [31:0]       ram_addr;
    logic              ram_rw;

    mem_arbiter #(
        .ADDR_WIDTH(32),
        .NUM_PORTS (NP)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush_in         (flush_in),
        .req_in           (req_in),
        .we_in            (we_in),
        .size_in          (size_in),
        .addr_in          (addr_in),
        .wdata_in         (wdata_in),
        .done_out         (done_out),
        .rdata_out        (rdata_out),
        .ram_data_in      (ram_din),
        .ram_data_out     (ram_dout),
        .ram_address_out  (ram_addr),
        .ram_rw_signal_out(ram_rw)
    );

    always #5 clk = ~clk;

    // Byte RAM, synchronous read, indexed by the low 16 address bits.
    logic [7:0]  mem [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_a  = '0;
    logic [7:0]  pl_d  = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (ram_rw) mem[ram_addr[15:0]] <= ram_dout;
        ram_din <= mem[ram_addr[15:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;
    int rw_cnt = 0;
    int done_cnt = 0;
    logic [NP-1:0] last_done = '0;
    logic [31:0]   last_rdata = '0;
    int          ord[$];
    logic [31:0] rq[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: on each grant, expand the access into the
    // expected per-cycle bus trace.
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [7:0]  data;
        logic [NP-1:0] done;
        logic [31:0] rdata;
    } rec_t;

    rec_t cur = '{K_IDLE, 32'h0, 8'h0, '0, 32'h0};
    rec_t mq[$];
    int   mrr = 0;

    function automatic void push_script(input int p, input bit we,
                                        input int n, input logic [31:0] a,
                                        input logic [31:0] wd);
        rec_t        r;
        logic [31:0] rd;
        logic [31:0] ai;
        rd = '0;
        for (int i = 0; i < n; i++) begin
            ai      = a + i;
            r.kind  = we ? K_BW : K_BR;
            r.addr  = ai;
            r.data  = wd[8*i +: 8];
            r.done  = '0;
            r.rdata = '0;
            mq.push_back(r);
            rd[8*i +: 8] = mem[ai[15:0]];
        end
        if (!we) begin
            r.kind = K_BR;
            r.addr = a + n - 1;
            r.data = '0;
            mq.push_back(r);
        end
        r.kind  = K_DN;
        r.addr  = '0;
        r.data  = '0;
        r.done  = NP'(1) << p;
        r.rdata = we ? 32'h0 : rd;
        mq.push_back(r);
    endfunction

    task automatic model_step();
        int g;
        int pp;
        int n;
        logic [1:0] sz;
        if (!rst_n) begin
            cur.kind = K_IDLE;
            mq.delete();
            mrr = 0;
            return;
        end
        if (cur.kind == K_IDLE) begin
            g = -1;
            for (int k = 0; k < NP; k++) begin
                pp = (mrr + k) % NP;
                if (g < 0 && req_in[pp]) g = pp;
            end
            if (g >= 0) begin
                sz = size_in[2*g +: 2];
                n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
                push_script(g, we_in[g], n, addr_in[32*g +: 32],
                            wdata_in[32*g +: 32]);
                cur = mq.pop_front();
                mrr = (g + 1) % NP;
            end
        end else if (cur.kind == K_BR && flush_in) begin
            mq.delete();
            cur.kind = K_IDLE;
        end else if (mq.size() > 0) begin
            cur = mq.pop_front();
        end else begin
            cur.kind = K_IDLE;
        end
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    task automatic compare_cycle();
        logic [NP-1:0] ed;
        logic [31:0]   ea;
        if (!rst_n) begin
            chk("rst_done_rdata", 64'({done_out, rdata_out}), 64'h0);
            chk("rst_ram", 64'({ram_addr, ram_dout, ram_rw}), 64'h0);
            return;
        end
        ed = (cur.kind == K_DN) ? cur.done : '0;
        ea = (cur.kind == K_BW || cur.kind == K_BR) ? cur.addr : 32'h0;
        chk("done", 64'(done_out), 64'(ed));
        chk("rw", 64'(ram_rw), 64'(cur.kind == K_BW));
        chk("addr", 64'(ram_addr), 64'(ea));
        if (cur.kind != K_BR)
            chk("wbyte", 64'(ram_dout),
                64'((cur.kind == K_BW) ? cur.data : 8'h0));
        if (cur.kind == K_DN)
            chk("rdata", 64'(rdata_out), 64'(cur.rdata));
        if (ram_rw) rw_cnt++;
        if (done_out != '0) begin
            done_cnt++;
            last_done  = done_out;
            last_rdata = rdata_out;
            for (int p = 0; p < NP; p++) if (done_out[p]) ord.push_back(p);
            rq.push_back(rdata_out);
        end
    endtask

    always @(negedge clk) compare_cycle();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pl(input logic [15:0] a, input logic [7:0] d);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic set_req(input int p, input bit we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        req_in[p]         = 1'b1;
        we_in[p]          = we;
        size_in[2*p +: 2] = sz;
        addr_in[32*p +: 32]  = a;
        wdata_in[32*p +: 32] = wd;
    endtask

    task automatic wait_done(input int p, input int c0, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done_out[p]) begin
                seen = 1'b1;
                lat  = cyc - c0;
            end
        end
        chk("done_seen", 64'(seen), 64'h1);
        tick();
        req_in[p] = 1'b0;
    endtask

    task automatic run(input int p, input bit we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat);
        int c0;
        set_req(p, we, sz, a, wd);
        c0 = cyc;
        wait_done(p, c0, lat);
        tick();
    endtask

    initial begin
        int lat;
        int c0;
        int d0;
        int seen;

        tick();
        pl(16'h0100, 8'h11); pl(16'h0101, 8'h22);
        pl(16'h0102, 8'h33); pl(16'h0103, 8'h44);
        pl(16'h2000, 8'hAA); pl(16'h2001, 8'hBB);
        pl(16'h2002, 8'hCC); pl(16'h2003, 8'hDD);
        pl(16'hFFFF, 8'h7F); pl(16'h0000, 8'h80);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a 4-byte write
        set_req(0, 1'b1, 2'd2, 32'h300, 32'hA1B2C3D4);
        tick();
        tick();
        chk("pre_rst_addr", 64'(ram_addr), 64'h301);
        chk("pre_rst_rw", 64'(ram_rw), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rw", 64'(ram_rw), 64'h0);
        chk("arst_addr", 64'(ram_addr), 64'h0);
        chk("arst_wbyte", 64'(ram_dout), 64'h0);
        chk("arst_done", 64'({done_out, rdata_out}), 64'h0);
        req_in = '0;
        we_in  = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // 4-byte read by port 0
        d0 = done_cnt;
        run(0, 1'b0, 2'd2, 32'h100, 32'h0, lat);
        chk("rd4_data", 64'(last_rdata), 64'h44332211);
        chk("rd4_port", 64'(last_done), 64'h1);
        chk("rd4_lat", 64'(lat), 64'd6);
        chk("rd4_pulses", 64'(done_cnt - d0), 64'd1);

        // 2-byte write by port 1
        rw_cnt = 0;
        run(1, 1'b1, 2'd1, 32'h2000, 32'hABCD1234, lat);
        chk("wr2_lat", 64'(lat), 64'd3);
        chk("wr2_rwcyc", 64'(rw_cnt), 64'd2);
        chk("wr2_port", 64'(last_done), 64'h2);
        chk("wr2_mem", 64'({mem[16'h2003], mem[16'h2002],
                            mem[16'h2001], mem[16'h2000]}),
            64'hDDCC1234);

        // Contention: both ports hold 1-byte reads
        ord.delete();
        rq.delete();
        set_req(0, 1'b0, 2'd0, 32'h100, 32'h0);
        set_req(1, 1'b0, 2'd0, 32'h2001, 32'h0);
        seen = 0;
        for (int k = 0; k < 80 && seen < 4; k++) begin
            @(negedge clk);
            if (done_out != '0) seen++;
        end
        tick();
        req_in = '0;
        tick();
        chk("cont_cnt", 64'(ord.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ord.size()) begin
                chk("cont_order", 64'(ord[i]), 64'(i % 2));
                chk("cont_rdata", 64'(rq[i]),
                    (i % 2 == 1) ? 64'h12 : 64'h11);
            end
        end

        // Flush a 4-byte read after two bytes issued
        d0 = done_cnt;
        set_req(0, 1'b0, 2'd2, 32'h100, 32'h0);
        tick();
        tick();
        tick();
        flush_in = 1'b1;
        tick();
        flush_in  = 1'b0;
        req_in[0] = 1'b0;
        chk("fl_idle", 64'({ram_addr, ram_rw}), 64'h0);
        set_req(1, 1'b0, 2'd0, 32'h2000, 32'h0);
        c0 = cyc;
        wait_done(1, c0, lat);
        tick();
        chk("fl_pulses", 64'(done_cnt - d0), 64'd1);
        chk("fl_port", 64'(last_done), 64'h2);
        chk("fl_rdata", 64'(last_rdata), 64'h34);
        chk("fl_lat", 64'(lat), 64'd3);

        // Flush has no effect on a write
        set_req(0, 1'b1, 2'd2, 32'h400, 32'h55667788);
        c0 = cyc;
        tick();
        tick();
        tick();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        wait_done(0, c0, lat);
        tick();
        chk("flw_lat", 64'(lat), 64'd5);
        chk("flw_mem", 64'({mem[16'h0403], mem[16'h0402],
                            mem[16'h0401], mem[16'h0400]}),
            64'h55667788);

        // 2-byte read across the top of the address space
        run(1, 1'b0, 2'd1, 32'hFFFFFFFF, 32'h0, lat);
        chk("wrap_rdata", 64'(last_rdata), 64'h0000807F);
        chk("wrap_lat", 64'(lat), 64'd4);

        // size 3 behaves as 4 bytes
        run(0, 1'b0, 2'd3, 32'h100, 32'h0, lat);
        chk("sz3_rdata", 64'(last_rdata), 64'h44332211);
        chk("sz3_lat", 64'(lat), 64'd6);

        // 1-byte write
        run(0, 1'b1, 2'd0, 32'h2003, 32'h000000EE, lat);
        chk("wr1_lat", 64'(lat), 64'd2);
        chk("wr1_mem", 64'({mem[16'h2003], mem[16'h2002]}), 64'hEECC);

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised byte-serial memory controller between NUM_PORTS requesters (instruction fetch, load/store unit, …) and the single-ported, byte-wide, synchronous-read `ram`. It accepts 1/2/4-byte little-endian read or write requests and arbitrates them round-robin. It serialises each access into per-byte RAM cycles and returns one completion pulse per access. It can abort an in-flight read on pipeline flush.

## Interface
- `ADDR_WIDTH`, 32, RAM address width.
- `NUM_PORTS`, 2, number of requesting channels, ≥1; port index 0 is the lowest.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `flush_in`  in  1  abort an in-flight read (branch mispredict).
- `req_in`  in  NUM_PORTS  per-port request; held high until that port's `done_out` bit.
- `we_in`  in  NUM_PORTS  per-port 1=write, 0=read.
- `size_in`  in  2*NUM_PORTS  per-port log2 byte count: 0→1B, 1→2B, 2→4B, 3→treated as 4B.
- `addr_in`  in  ADDR_WIDTH*NUM_PORTS  per-port byte address of the lowest byte.
- `wdata_in`  in  32*NUM_PORTS  per-port write data; byte i is bits [8i+7:8i].
- `done_out`  out  NUM_PORTS  one-cycle completion pulse to the served port.
- `rdata_out`  out  32  read result, zero-extended; valid while any `done_out` bit is high.
- `ram_data_in`  in  8  RAM read byte; corresponds to the address driven on the previous cycle.
- `ram_data_out`  out  8  RAM write byte.
- `ram_address_out`  out  ADDR_WIDTH  RAM byte address.
- `ram_rw_signal_out`  out  1  1=write, 0=read.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - RAM outputs are 0; `ram_rw_signal_out`=0.
  - If any `req_in` bit is set, grant the first requesting port at or after pointer `rr` (cyclic).
  - Latch the granted port's we/size/addr/wdata, clear the issue count `ic` and receive count `rc`, and go to BUSY.
  - Set `rr` = (granted+1) mod NUM_PORTS.
- Byte count N = 1, 2 or 4 from the latched size.
- BUSY, write:
  - While `ic`<N, drive address = addr+`ic`, data = byte `ic` of wdata, rw=1, and increment `ic`.
  - After the edge that issues byte N-1, go to DONE.
- BUSY, read:
  - While `ic`<N, drive address = addr+`ic`, rw=0, and increment `ic`.
  - On every edge in BUSY where `ic`≥1, store `ram_data_in` into byte `rc` of the result and increment `rc`.
  - After the edge that captures byte N-1, go to DONE.
  - Address stays at addr+N-1 with rw=0 during the final capture cycle.
- DONE:
  - `done_out[granted]`=1 and `rdata_out` = result; unwritten upper bytes are 0. For writes, `rdata_out`=0.
  - RAM outputs are 0. Next edge goes to IDLE.
- Address arithmetic: addr+`ic` is computed modulo 2^ADDR_WIDTH; 0xFFFFFFFF+1 wraps to 0.
- Flush:
  - `flush_in` high at an edge while in BUSY with a read: go to IDLE, no `done_out`, result discarded. `rr` keeps its post-grant value.
  - Flush is ignored for writes, which always complete.
  - Flush is ignored in IDLE and DONE; a read already in DONE still pulses.
- A request whose `req_in` drops before grant is never served. Requests may change freely while not granted.

## Timing
- Reset (`rst_n`=0, asynchronous) forces:
  - state=IDLE, `rr`=0;
  - `done_out`=0, `rdata_out`=0;
  - `ram_address_out`=0, `ram_data_out`=0, `ram_rw_signal_out`=0.
- Reset mid-access abandons the access; a partially written word stays partially written.
- Let edge E0 be the grant edge (IDLE→BUSY).
  - Write of N bytes: RAM write cycles follow E0, E0+1 … E0+N-1. `done_out` is high during the cycle after edge E0+N.
  - Read of N bytes: `done_out` is high during the cycle after edge E0+N+1.
  - Latency from request to done: 4B read 6 cycles, 4B write 5 cycles, 1B read 3 cycles (`req_in` sampled at E0).
- DONE→IDLE costs one cycle; the earliest next grant is the edge ending the IDLE cycle after DONE.
- The requester must drop `req_in` on the edge that ends its `done_out` cycle, or it is re-served.
- `rdata_out` and `done_out` are registered; RAM outputs are combinational from registered state only.

## Test plan
- Reset: hold `rst_n`=0 mid-BUSY → all outputs 0 immediately (asynchronous). Release, then port 0 reads → served normally.
- 4B read: port 0 reads 0x100, RAM holds 11 22 33 44 → addresses 0x100..0x103 with rw=0, `rdata_out`=0x44332211, `done_out`=01 exactly one cycle, 6 cycles after the request.
- 2B write: port 1 writes 0xABCD1234 at 0x2000 → RAM[0x2000]=0x34, RAM[0x2001]=0x12, rw=1 on exactly 2 cycles, `done_out`=10, 0x2002 untouched.
- Contention: both ports hold 1B read requests continuously for 4 grants → service order 0,1,0,1; each done pulse goes only to the served port.
- Flush: port 0 4B read, `flush_in` pulsed after 2 bytes issued → no `done_out`, FSM in IDLE next cycle, a following port 1 request is granted.
- Wrap and size: 2B read at 0xFFFFFFFF with RAM[0xFFFFFFFF]=0x7F, RAM[0]=0x80 → `rdata_out`=0x0000807F. size=3 → behaves as 4B.
